// File: rtl/if_fetch_if.sv
// if_fetch_if: instruction-memory request/grant and in-order response bus
interface if_fetch_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic               o_imem_req;
  logic [ADDR_W-1:0]  o_imem_addr;
  logic               i_imem_gnt;
  logic               i_imem_rvalid;
  logic [INSTR_W-1:0] i_imem_rdata;
  modport master (output o_imem_req, o_imem_addr, input i_imem_gnt, i_imem_rvalid, i_imem_rdata);
  modport slave (input o_imem_req, o_imem_addr, output i_imem_gnt, i_imem_rvalid, i_imem_rdata);
endinterface

// File: rtl/if_fetch.sv
// if_fetch: fetch PC, in-order imem requests, response FIFO and branch redirect
module if_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic               stall,
  input  logic               i_branch_taken,
  input  logic [ADDR_W-1:0]  i_branch_target,
  if_fetch_if.master         imem,
  output logic               o_valid,
  output logic [ADDR_W-1:0]  o_pc,
  output logic [INSTR_W-1:0] o_instr
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d, inflight_q, inflight_d, drop_q, drop_d;
  logic [ADDR_W-1:0]  pc_mem_q [DEPTH];
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic               grant, resp, push, pop;
  // request only while FIFO slots cover every outstanding request; head drives the outputs
  always_comb begin
    imem.o_imem_req  = aresetn & ~i_branch_taken & (({1'b0, count_q} + {1'b0, inflight_q}) < (CW+1)'(DEPTH));
    imem.o_imem_addr = fetch_pc_q;
    grant            = imem.o_imem_req & imem.i_imem_gnt;
    resp             = imem.i_imem_rvalid & (inflight_q != '0);
    push             = resp & (drop_q == '0) & ~i_branch_taken;
    o_valid          = count_q != '0;
    pop              = o_valid & ~stall & ~i_branch_taken;
    o_pc             = o_valid ? pc_mem_q[rd_ptr_q] : '0;
    o_instr          = o_valid ? instr_mem_q[rd_ptr_q] : '0;
  end
  // next state; a redirect empties the FIFO and marks every still-outstanding response stale
  always_comb begin
    fetch_pc_d = i_branch_taken ? i_branch_target : grant ? fetch_pc_q + ADDR_W'(4) : fetch_pc_q;
    resp_pc_d  = i_branch_taken ? i_branch_target : push ? resp_pc_q + ADDR_W'(4) : resp_pc_q;
    wr_ptr_d   = i_branch_taken ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d   = i_branch_taken ? '0 : rd_ptr_q + PW'(pop);
    count_d    = i_branch_taken ? '0 : count_q + CW'(push) - CW'(pop);
    inflight_d = inflight_q + CW'(grant) - CW'(resp);
    drop_d     = i_branch_taken ? inflight_q - CW'(resp) : drop_q - CW'(resp && (drop_q != '0));
  end
  // control state with asynchronous clear
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end
  // FIFO payload; entries are only read while counted, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= resp_pc_q;
      instr_mem_q[wr_ptr_q] <= imem.i_imem_rdata;
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed vectors plus redirect, backpressure and reset sequences
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] tgt = '0;
  logic        valid;
  logic [31:0] pc, instr;
  int          errors = 0, checks = 0, cyc = 0, lat = 1;
  logic        g;
  logic [31:0] ga;
  typedef struct { logic [31:0] addr; int due; } req_t;
  typedef struct { logic stall; logic v; logic [31:0] pc; logic req; logic [31:0] addr; } vec_t;
  req_t mq[$];
  vec_t tbl[12];

  if_fetch_if #(.ADDR_W(32), .INSTR_W(32)) bus();

  if_fetch #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0), .DEPTH(4)) dut (
    .clk(clk), .aresetn(aresetn), .stall(stall), .i_branch_taken(br), .i_branch_target(tgt),
    .imem(bus), .o_valid(valid), .o_pc(pc), .o_instr(instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return {a[23:0], 8'h13} ^ 32'h5A00_0000;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic chk_out(input string n, input logic v, input logic [31:0] p, input logic r, input logic [31:0] a);
    chk({n, " valid"}, 32'(valid), 32'(v));
    chk({n, " pc"}, pc, v ? p : 32'h0);
    chk({n, " instr"}, instr, v ? dat(p) : 32'h0);
    chk({n, " req"}, 32'(bus.o_imem_req), 32'(r));
    chk({n, " addr"}, bus.o_imem_addr, a);
  endtask

  task automatic drive();
    bus.i_imem_rvalid = (mq.size() > 0) && (mq[0].due <= cyc);
    bus.i_imem_rdata = '0;
    if (bus.i_imem_rvalid) bus.i_imem_rdata = dat(mq[0].addr);
    #1;
  endtask

  task automatic step();
    g = bus.o_imem_req & bus.i_imem_gnt;
    ga = bus.o_imem_addr;
    @(posedge clk);
    if (bus.i_imem_rvalid) void'(mq.pop_front());
    if (g) mq.push_back('{ga, cyc + lat});
    cyc++;
    #1;
  endtask

  task automatic do_reset(input int l);
    aresetn = 1'b0;
    br = 1'b0;
    stall = 1'b0;
    bus.i_imem_gnt = 1'b1;
    bus.i_imem_rvalid = 1'b0;
    bus.i_imem_rdata = '0;
    mq.delete();
    lat = l;
    repeat (2) @(posedge clk);
    #1;
    chk_out("in reset", 1'b0, 32'h0, 1'b0, 32'h0);
    aresetn = 1'b1;
    cyc = 0;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd0};
    tbl[1]  = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd4};
    tbl[2]  = '{1'b0, 1'b1, 32'd0,  1'b1, 32'd8};
    tbl[3]  = '{1'b0, 1'b1, 32'd4,  1'b1, 32'd12};
    tbl[4]  = '{1'b1, 1'b1, 32'd8,  1'b1, 32'd16};
    tbl[5]  = '{1'b1, 1'b1, 32'd8,  1'b1, 32'd20};
    tbl[6]  = '{1'b1, 1'b1, 32'd8,  1'b0, 32'd24};
    tbl[7]  = '{1'b0, 1'b1, 32'd8,  1'b0, 32'd24};
    tbl[8]  = '{1'b0, 1'b1, 32'd12, 1'b1, 32'd24};
    tbl[9]  = '{1'b0, 1'b1, 32'd16, 1'b1, 32'd28};
    tbl[10] = '{1'b0, 1'b1, 32'd20, 1'b1, 32'd32};
    tbl[11] = '{1'b0, 1'b1, 32'd24, 1'b1, 32'd36};

    // sequential fetch and stall, 1-cycle memory
    do_reset(1);
    for (int i = 0; i < 12; i++) begin
      stall = tbl[i].stall;
      drive();
      chk_out($sformatf("seq c%0d", i), tbl[i].v, tbl[i].pc, tbl[i].req, tbl[i].addr);
      step();
    end

    // redirect with two requests in flight, 3-cycle memory
    do_reset(3);
    drive(); step();
    drive(); step();
    br = 1'b1;
    tgt = 32'h100;
    drive();
    chk("redir req", 32'(bus.o_imem_req), 32'h0);
    step();
    br = 1'b0;
    for (int i = 3; i < 7; i++) begin
      drive();
      chk($sformatf("redir c%0d valid", i), 32'(valid), 32'h0);
      if (i == 3) chk("redir target addr", bus.o_imem_addr, 32'h100);
      step();
    end
    drive(); chk_out("redir c7", 1'b1, 32'h100, 1'b0, 32'h110); step();
    drive(); chk_out("redir c8", 1'b1, 32'h104, 1'b1, 32'h110); step();

    // redirect while stalled with two entries queued and a response arriving
    do_reset(1);
    drive(); step();
    drive(); step();
    stall = 1'b1;
    drive(); chk_out("rs c2", 1'b1, 32'h0, 1'b1, 32'h8); step();
    br = 1'b1;
    tgt = 32'h200;
    drive();
    chk("rs c3 valid", 32'(valid), 32'h1);
    chk("rs c3 req", 32'(bus.o_imem_req), 32'h0);
    step();
    br = 1'b0;
    stall = 1'b0;
    drive(); chk_out("rs c4", 1'b0, 32'h0, 1'b1, 32'h200); step();
    drive(); chk_out("rs c5", 1'b0, 32'h0, 1'b1, 32'h204); step();
    drive(); chk_out("rs c6", 1'b1, 32'h200, 1'b1, 32'h208); step();
    drive(); chk_out("rs c7", 1'b1, 32'h204, 1'b1, 32'h20C); step();

    // grant backpressure
    do_reset(1);
    bus.i_imem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive();
      chk_out($sformatf("bp c%0d", i), 1'b0, 32'h0, 1'b1, 32'h0);
      step();
    end
    bus.i_imem_gnt = 1'b1;
    drive(); chk_out("bp c4", 1'b0, 32'h0, 1'b1, 32'h0); step();
    drive(); chk_out("bp c5", 1'b0, 32'h0, 1'b1, 32'h4); step();
    drive(); chk_out("bp c6", 1'b1, 32'h0, 1'b1, 32'h8); step();
    drive(); chk_out("bp c7", 1'b1, 32'h4, 1'b1, 32'hC); step();

    // asynchronous reset mid-operation with two entries queued
    do_reset(1);
    drive(); step();
    drive(); step();
    stall = 1'b1;
    drive(); step();
    drive();
    chk("mid c3 valid", 32'(valid), 32'h1);
    aresetn = 1'b0;
    #1;
    chk_out("mid async", 1'b0, 32'h0, 1'b0, 32'h0);
    do_reset(1);
    drive(); chk_out("post c0", 1'b0, 32'h0, 1'b1, 32'h0); step();
    drive(); chk_out("post c1", 1'b0, 32'h0, 1'b1, 32'h4); step();
    drive(); chk_out("post c2", 1'b1, 32'h0, 1'b1, 32'h8); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage for the b-risc five-stage pipeline. It owns the fetch PC, issues in-order word requests to instruction memory over a request/grant and response-valid handshake, and buffers returned instructions in a small FIFO. It presents the head entry (PC and instruction) to the decode stage and holds it while decode stalls. It applies taken-branch redirects from execute by flushing the FIFO and discarding in-flight responses.

## Interface
Parameters:
- RESET_PC, default 0: first fetch address after reset.
- DEPTH, default 2: FIFO entries and maximum in-flight requests. Legal values are 2, 4 or 8.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- aresetn  in  1  reset, asynchronous, active-low.
- stall  in  1  decode stage is stalling; hold the current output entry.
- i_branch_taken  in  1  redirect request from execute.
- i_branch_target  in  ADDR_W  redirect PC.
- o_imem_req  out  1  fetch request valid.
- o_imem_addr  out  ADDR_W  fetch address, word aligned.
- i_imem_gnt  in  1  memory accepts the request this cycle.
- i_imem_rvalid  in  1  response valid. Responses return in order, at least 1 cycle after grant.
- i_imem_rdata  in  INSTR_W  response instruction.
- o_valid  out  1  o_pc and o_instr hold a real instruction.
- o_pc  out  ADDR_W  PC of the head instruction.
- o_instr  out  INSTR_W  head instruction. Value is 0 when o_valid=0.

## Operation
State:
- fetch_pc: next request address.
- resp_pc: PC of the next accepted response.
- FIFO storage of {pc, instr}, DEPTH entries.
- count: number of FIFO entries, 0..DEPTH.
- inflight: granted requests not yet responded, 0..DEPTH.
- drop: responses still to be discarded, always ≤ inflight.

Request rules:
- o_imem_req = (count + inflight < DEPTH) & ~i_branch_taken.
- o_imem_addr = fetch_pc.
- A grant occurs when o_imem_req & i_imem_gnt. On a grant: fetch_pc += 4 (wraps modulo 2^ADDR_W) and inflight increments.
- While req=1 and gnt=0, o_imem_addr is held stable.

Response rules:
- Every rvalid decrements inflight.
- If drop>0: discard the data and decrement drop.
- Otherwise: push {resp_pc, rdata} and then resp_pc += 4.

Output and pop rules:
- o_valid = (count != 0). o_pc and o_instr come from the FIFO head, or 0 when the FIFO is empty.
- Pop when o_valid & ~stall & ~i_branch_taken.
- A push and a pop in the same cycle leave count unchanged.
- Overflow cannot occur because requests are gated by count + inflight.

Redirect (i_branch_taken=1) takes priority over stall, push and pop:
- count <= 0.
- fetch_pc <= i_branch_target and resp_pc <= i_branch_target.
- drop <= inflight minus 1 if rvalid is asserted this cycle.
- Any response arriving in the redirect cycle is discarded.
- No request is issued in the redirect cycle.

Other rules:
- rvalid with inflight=0 is a protocol violation. It is ignored and the FIFO is not pushed.
- On aresetn low, immediately and asynchronously: fetch_pc = resp_pc = RESET_PC; count = inflight = drop = 0. As a result o_valid = 0, o_pc = 0, o_instr = 0 and o_imem_req = 0, with req gated by the reset.
- A reset asserted mid-operation abandons in-flight requests. Memory is reset on the same signal.

## Timing
- First request: o_imem_req rises in the first cycle after aresetn deasserts, with o_imem_addr = RESET_PC.
- Latency: with a 1-cycle memory and gnt tied high, an instruction granted in cycle N is captured at the end of cycle N+1 and visible on o_valid/o_pc/o_instr in cycle N+2.
- Throughput: one instruction per cycle in steady state with DEPTH≥2 and 1-cycle memory.
- Registered outputs: o_pc, o_instr and o_valid come only from registered state; they do not depend combinationally on rdata.
- Combinational outputs: o_imem_req depends combinationally on i_branch_taken only.
- Redirect timing: with the redirect in cycle R, the first request to the target is issued in R+1. The first target instruction appears no earlier than R+3 with a 1-cycle memory.
- Stall: outputs are stable for every cycle stall=1. Fetch continues until count + inflight = DEPTH, then req=0.

## Test plan
1. Reset, then sequential fetch: RESET_PC=0, 1-cycle memory, gnt=1. o_valid first high in cycle 2 after reset release, then o_pc = 0, 4, 8, 12 on consecutive cycles with the matching rdata.
2. Stall: hold stall=1 for 3 cycles while o_pc=8. Outputs stay at pc 8, count reaches 2 and req drops to 0. After release the sequence is 8, 12, 16 with no loss or duplication.
3. Redirect with traffic in flight: memory latency 3 and 2 requests in flight; pulse i_branch_taken with target 0x100. Both stale responses are dropped and the next valid outputs are pc 0x100, 0x104 with the correct data.
4. Redirect during stall: stall=1 with 2 entries queued, branch to 0x200. Next cycle o_valid=0 and the first valid output is 0x200.
5. Grant backpressure: gnt=0 for 4 cycles. o_imem_req=1 and o_imem_addr stay constant. After gnt returns, fetch resumes with no skipped address.
6. Reset mid-operation: drop aresetn between edges while count=2. o_valid=0 and o_imem_req=0 immediately. After release the first request is to RESET_PC.
